// File: rtl/vram_pkg.sv
// Shared constants and FSM encoding for the CPU-side screen VRAM bridge.
package vram_pkg;

  localparam int VRAM_ADDR_W = 13;
  localparam int VRAM_DATA_W = 16;

  localparam logic [14:0] SCREEN_BASE = 15'h4000;
  // Top two Hack address bits that select the 8K-word screen window.
  localparam logic [1:0]  WIN_SEL     = SCREEN_BASE[14:13];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD1  = 2'd1,
    RD2  = 2'd2,
    FILL = 2'd3
  } state_t;

endpackage

// File: rtl/vram_fill_engine.sv
// Fill engine: pending request, latched fill word, address counter, busy/done.
module vram_fill_engine #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 16,
  parameter int FILL_WORDS = 8192
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_value,
  input  logic              go,
  input  logic              in_fill,
  output logic              pending,
  output logic              busy,
  output logic              done,
  output logic              fill_last,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [DATA_W-1:0] fill_data
);

  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(FILL_WORDS - 1);

  // One extra bit so the counter cannot wrap before the last word is issued.
  logic [ADDR_W:0]   cnt;
  logic [DATA_W-1:0] value_q;
  logic              last_q;

  assign fill_last = (cnt == LAST_CNT);
  assign fill_addr = cnt[ADDR_W-1:0];
  assign fill_data = value_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      last_q  <= 1'b0;
      cnt     <= '0;
    end else begin
      // done trails the final write by one cycle, aligned with wren dropping.
      last_q <= in_fill && fill_last;
      done   <= last_q;
      if (go) begin
        pending <= 1'b0;
        busy    <= 1'b1;
        cnt     <= '0;
      end else begin
        if (fill_start && !in_fill)
          pending <= 1'b1;
        if (in_fill) begin
          cnt <= cnt + 1'b1;
          if (fill_last)
            busy <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (go)
      value_q <= fill_value;
  end

endmodule

// File: rtl/vram_cpu_bridge.sv
// CPU front end for VRAM port A: screen-window decode, registered writes,
// stalled fixed-latency reads and a hardware fill engine.
module vram_cpu_bridge import vram_pkg::*; #(
  parameter int ADDR_W     = VRAM_ADDR_W,
  parameter int DATA_W     = VRAM_DATA_W,
  parameter int FILL_WORDS = 8192
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [14:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  input  logic              cpu_re,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic              cpu_stall,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_value,
  output logic              fill_busy,
  output logic              fill_done,
  output logic [ADDR_W-1:0] vram_address,
  output logic [DATA_W-1:0] vram_data,
  output logic              vram_wren,
  input  logic [DATA_W-1:0] vram_q
);

  state_t            state, state_nxt;
  logic              hit, hit_req, go;
  logic              pending, fill_last;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_data;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d, rdata_d;
  logic              wren_d, rvalid_d;

  assign hit     = (cpu_addr[14:13] == WIN_SEL);
  assign hit_req = hit && (cpu_we || cpu_re);

  vram_fill_engine #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .FILL_WORDS (FILL_WORDS)
  ) u_fill (
    .clk        (clk),
    .rst        (rst),
    .fill_start (fill_start),
    .fill_value (fill_value),
    .go         (go),
    .in_fill    (state == FILL),
    .pending    (pending),
    .busy       (fill_busy),
    .done       (fill_done),
    .fill_last  (fill_last),
    .fill_addr  (fill_addr),
    .fill_data  (fill_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        // A write wins over a simultaneous read; CPU hits win over a pending fill.
        if (hit_req && !cpu_we) state_nxt = RD1;
        else if (!hit_req && pending) state_nxt = FILL;
      end
      RD1:  state_nxt = RD2;
      RD2:  state_nxt = IDLE;
      FILL: if (fill_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    addr_d    = vram_address;
    data_d    = vram_data;
    rdata_d   = cpu_rdata;
    wren_d    = 1'b0;
    rvalid_d  = 1'b0;
    cpu_stall = 1'b0;
    go        = 1'b0;
    case (state)
      IDLE: begin
        if (hit_req) begin
          addr_d = cpu_addr[ADDR_W-1:0];
          if (cpu_we) begin
            data_d = cpu_wdata;
            wren_d = 1'b1;
          end
        end else if (pending) begin
          go = 1'b1;
        end
      end
      RD1: cpu_stall = 1'b1;
      RD2: begin
        cpu_stall = 1'b1;
        rdata_d   = vram_q;
        rvalid_d  = 1'b1;
      end
      FILL: begin
        cpu_stall = 1'b1;
        addr_d    = fill_addr;
        data_d    = fill_data;
        wren_d    = 1'b1;
      end
      default: ;
    endcase
  end

  // Port-A and CPU read-data register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      vram_address <= '0;
      vram_data    <= '0;
      vram_wren    <= 1'b0;
      cpu_rdata    <= '0;
      cpu_rvalid   <= 1'b0;
    end else begin
      vram_address <= addr_d;
      vram_data    <= data_d;
      vram_wren    <= wren_d;
      cpu_rdata    <= rdata_d;
      cpu_rvalid   <= rvalid_d;
    end
  end

endmodule

// File: tb/tb_vram_cpu_bridge.sv
// Directed bench for vram_cpu_bridge with a behavioural 1-cycle VRAM on port A.
module tb_vram_cpu_bridge;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 16;
  localparam int FW     = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [14:0]       cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_we, cpu_re;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid, cpu_stall;
  logic              fill_start;
  logic [DATA_W-1:0] fill_value;
  logic              fill_busy, fill_done;
  logic [ADDR_W-1:0] vram_address;
  logic [DATA_W-1:0] vram_data;
  logic              vram_wren;
  logic [DATA_W-1:0] vram_q;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  int n_chk  = 0;
  int n_pass = 0;
  int busy_cnt, done_cnt, wren_cnt;

  always #5 clk = ~clk;

  vram_cpu_bridge #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .FILL_WORDS (FW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_we       (cpu_we),
    .cpu_re       (cpu_re),
    .cpu_rdata    (cpu_rdata),
    .cpu_rvalid   (cpu_rvalid),
    .cpu_stall    (cpu_stall),
    .fill_start   (fill_start),
    .fill_value   (fill_value),
    .fill_busy    (fill_busy),
    .fill_done    (fill_done),
    .vram_address (vram_address),
    .vram_data    (vram_data),
    .vram_wren    (vram_wren),
    .vram_q       (vram_q)
  );

  // Port-A VRAM model: registered address, read-old-data on a same-edge write.
  always @(posedge clk) begin
    if (vram_wren) mem[vram_address] <= vram_data;
    vram_q <= mem[vram_address];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Full read transaction: accept, two stalled cycles, rvalid on the third edge.
  task automatic do_read(input logic [14:0] addr, input logic [15:0] exp, input string tag);
    cpu_addr = addr;
    cpu_re   = 1'b1;
    tick;
    check({tag, "_stall1"}, cpu_stall, 1);
    check({tag, "_rv_early"}, cpu_rvalid, 0);
    tick;
    check({tag, "_stall2"}, cpu_stall, 1);
    tick;
    check({tag, "_rvalid"}, cpu_rvalid, 1);
    check({tag, "_rdata"}, cpu_rdata, exp);
    check({tag, "_unstall"}, cpu_stall, 0);
    cpu_re = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [14:0] nh_addr [0:3];
    logic        nh_we   [0:3];
    nh_addr = '{15'h6000, 15'h3FFF, 15'h6000, 15'h3FFF};
    nh_we   = '{1'b1, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; cpu_re = 1'b0;
    fill_start = 1'b0; fill_value = '0;
    tick; tick;
    check("rst_wren",   vram_wren, 0);
    check("rst_addr",   vram_address, 0);
    check("rst_data",   vram_data, 0);
    check("rst_stall",  cpu_stall, 0);
    check("rst_rvalid", cpu_rvalid, 0);
    check("rst_rdata",  cpu_rdata, 0);
    check("rst_busy",   fill_busy, 0);
    check("rst_done",   fill_done, 0);
    rst = 1'b0;
    tick;

    // Single write, then back-to-back writes
    cpu_addr = 15'h4005; cpu_wdata = 16'hBEEF; cpu_we = 1'b1;
    #1 check("wr_nostall", cpu_stall, 0);
    tick;
    cpu_we = 1'b0;
    check("wr_wren", vram_wren, 1);
    check("wr_addr", vram_address, 13'd5);
    check("wr_data", vram_data, 16'hBEEF);
    tick;
    check("wr_one_cycle", vram_wren, 0);

    cpu_addr = 15'h4010; cpu_wdata = 16'h1111; cpu_we = 1'b1;
    tick;
    check("b2b_addr0", vram_address, 13'h10);
    check("b2b_data0", vram_data, 16'h1111);
    cpu_addr = 15'h4011; cpu_wdata = 16'h2222;
    tick;
    cpu_we = 1'b0;
    check("b2b_wren1", vram_wren, 1);
    check("b2b_addr1", vram_address, 13'h11);
    check("b2b_data1", vram_data, 16'h2222);
    tick;

    do_read(15'h4005, 16'hBEEF, "rd5");
    tick;
    check("rd5_rv_pulse", cpu_rvalid, 0);
    do_read(15'h4011, 16'h2222, "rd11");

    // Accesses outside the screen window
    for (int i = 0; i < 4; i++) begin
      cpu_addr = nh_addr[i]; cpu_wdata = 16'hDEAD;
      cpu_we = nh_we[i]; cpu_re = ~nh_we[i];
      wren_cnt = 0; busy_cnt = 0; done_cnt = 0;
      repeat (4) begin
        tick;
        wren_cnt += vram_wren;
        busy_cnt += cpu_stall;
        done_cnt += cpu_rvalid;
      end
      check($sformatf("nohit%0d_wren", i), wren_cnt, 0);
      check($sformatf("nohit%0d_stall", i), busy_cnt, 0);
      check($sformatf("nohit%0d_rvalid", i), done_cnt, 0);
    end
    cpu_we = 1'b0; cpu_re = 1'b0;
    tick;

    // Write and read together behave as a write only
    cpu_addr = 15'h4001; cpu_wdata = 16'h1234; cpu_we = 1'b1; cpu_re = 1'b1;
    #1 check("wr_rd_nostall", cpu_stall, 0);
    tick;
    cpu_we = 1'b0; cpu_re = 1'b0;
    check("wr_rd_wren", vram_wren, 1);
    check("wr_rd_addr", vram_address, 13'd1);
    check("wr_rd_data", vram_data, 16'h1234);
    check("wr_rd_stall", cpu_stall, 0);
    done_cnt = 0;
    repeat (3) begin
      tick;
      done_cnt += cpu_rvalid;
    end
    check("wr_rd_no_rvalid", done_cnt, 0);

    // Fill requested alongside a hit write to 0x4002
    cpu_addr = 15'h4002; cpu_wdata = 16'hABCD; cpu_we = 1'b1;
    fill_start = 1'b1; fill_value = 16'hFFFF;
    tick;
    cpu_we = 1'b0; fill_start = 1'b0;
    check("fs_wr_first", vram_wren, 1);
    check("fs_wr_addr", vram_address, 13'd2);
    check("fs_wr_data", vram_data, 16'hABCD);
    check("fs_not_busy", fill_busy, 0);
    tick;
    fill_value = 16'h0000;
    check("fill_busy_on", fill_busy, 1);
    check("fill_stall_on", cpu_stall, 1);
    check("fill_gap_wren", vram_wren, 0);
    busy_cnt = fill_busy; done_cnt = 0; wren_cnt = 0;
    for (int k = 0; k < FW; k++) begin
      tick;
      busy_cnt += fill_busy;
      done_cnt += fill_done;
      wren_cnt += vram_wren;
      check($sformatf("fill_addr%0d", k), vram_address, k);
      check($sformatf("fill_data%0d", k), vram_data, 16'hFFFF);
    end
    check("fill_wren_count", wren_cnt, FW);
    tick;
    check("fill_end_wren", vram_wren, 0);
    check("fill_done_pulse", fill_done, 1);
    done_cnt += fill_done;
    tick;
    done_cnt += fill_done;
    tick;
    done_cnt += fill_done;
    check("fill_busy_cycles", busy_cnt, FW);
    check("fill_done_count", done_cnt, 1);

    for (int k = 0; k < FW; k++) begin
      do_read(15'h4000 + 15'(k), 16'hFFFF, $sformatf("fillrd%0d", k));
    end
    tick;

    // Reset while the fill is at address 7
    fill_start = 1'b1; fill_value = 16'h5A5A;
    tick;
    fill_start = 1'b0;
    tick;
    for (int k = 0; k < 8; k++) tick;
    check("abort_at7_addr", vram_address, 13'd7);
    check("abort_at7_wren", vram_wren, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("abort_wren", vram_wren, 0);
    check("abort_busy", fill_busy, 0);
    check("abort_stall", cpu_stall, 0);
    done_cnt = fill_done; wren_cnt = 0;
    repeat (5) begin
      tick;
      done_cnt += fill_done;
      wren_cnt += vram_wren;
    end
    check("abort_no_done", done_cnt, 0);
    check("abort_no_wren", wren_cnt, 0);
    do_read(15'h4007, 16'h5A5A, "abort_rd7");
    do_read(15'h4008, 16'hFFFF, "abort_rd8");
    tick;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vram_cpu_bridge.md
Name: vram_cpu_bridge

Overview:
- CPU-side front end for the dual-port screen VRAM; drives VRAM port A, while the VGA scan-out engine owns port B.
- Decodes Hack screen-window accesses (0x4000-0x5FFF) into registered VRAM writes and fixed-latency reads, stalling the CPU while a read is in flight.
- Includes a hardware fill engine that writes one value to every screen word, for clear-screen and boot.

Parameters:
- ADDR_W, 13, VRAM word-address width.
- DATA_W, 16, word width.
- FILL_WORDS, 8192, words written by a fill; benches may shrink it.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cpu_addr  in  15  Hack data-memory address
- cpu_wdata  in  16  write data
- cpu_we  in  1  write request
- cpu_re  in  1  read request
- cpu_rdata  out  16  read data, valid while cpu_rvalid=1
- cpu_rvalid  out  1  one-cycle read-data strobe
- cpu_stall  out  1  CPU must hold its request and not advance
- fill_start  in  1  fill request pulse
- fill_value  in  16  fill word, sampled when the fill starts
- fill_busy  out  1  fill in progress
- fill_done  out  1  one-cycle pulse after the last fill write
- vram_address  out  13  to VRAM address_a
- vram_data  out  16  to VRAM data_a
- vram_wren  out  1  to VRAM wren_a
- vram_q  in  16  from VRAM q_a (registered address, 1-cycle read)

Behaviour:
- Reset: synchronous, active-high. All outputs go to 0, FSM to IDLE, pending-fill flag cleared.
- Reset mid-fill: aborts the fill; vram_wren=0 from the next cycle; no fill_done pulse.
- hit = (cpu_addr[14:13]==2'b10). Non-hit accesses are ignored: no VRAM activity, no stall, no rvalid.
- FSM states: IDLE, RD1, RD2, FILL. All VRAM outputs are registered.
- IDLE, hit and cpu_we at edge E0:
  - vram_address<=cpu_addr[12:0], vram_data<=cpu_wdata, vram_wren<=1 for exactly one cycle.
  - No stall; stay in IDLE. Back-to-back writes are accepted every cycle.
- IDLE, hit and cpu_re (cpu_we=0) at E0:
  - vram_address<=cpu_addr[12:0], vram_wren<=0, go to RD1; cpu_stall=1 in RD1 and RD2.
  - E1: VRAM samples the address; go to RD2.
  - E2: cpu_rdata<=vram_q, cpu_rvalid<=1 for one cycle, go to IDLE.
  - Latency from acceptance to rvalid is 3 edges (rvalid high after E2).
- cpu_we and cpu_re together: treated as a write; the read is dropped.
- fill_start sets a pending flag in any state other than FILL.
- In IDLE:
  - A CPU hit has priority over a pending fill.
  - Otherwise a pending fill latches fill_value, clears the counter and pending flag, and enters FILL.
- FILL:
  - Each cycle: vram_address<=counter, vram_data<=latched value, vram_wren<=1, counter+1.
  - fill_busy=1 and cpu_stall=1 throughout. CPU requests are held off, not dropped; the CPU holds them.
  - After address FILL_WORDS-1 is written: vram_wren<=0, fill_done<=1 for one cycle, fill_busy<=0, go to IDLE.
  - The counter is ADDR_W+1 bits, so it never wraps mid-fill.
- fill_start during FILL is ignored; it does not re-arm the pending flag.
- vram_wren is never high on two cycles with the same address in READ states.
- Port B is untouched. A scan-out read of an address being written sees the VRAM's mixed-port behaviour; the bridge does not resolve that.

Decomposition:
- vram_pkg holds:
  - SCREEN_BASE (15'h4000)
  - ADDR_W and DATA_W defaults
  - the window-decode constant 2'b10
  - the FSM state enum {IDLE, RD1, RD2, FILL}
- One natural sub-module, vram_fill_engine: owns the counter, latched fill value, pending flag, busy and done. The bridge muxes its address, data and wren onto the port-A outputs.

Test Plan:
- Write 0x4005 data 16'hBEEF, no stall -> next cycle vram_address=5, vram_data=BEEF, vram_wren=1 for one cycle; later read of 0x4005 -> cpu_rvalid 3 edges after acceptance, cpu_rdata=BEEF, cpu_stall=1 exactly 2 cycles.
- Access 0x6000 (keyboard) and 0x3FFF, read and write -> vram_wren stays 0, no stall, no rvalid.
- FILL_WORDS=16, fill_value=16'hFFFF, start -> 16 consecutive writes to addresses 0..15 with FFFF; fill_busy high 16 cycles, single fill_done pulse, then all 16 words read back FFFF.
- fill_start in the same cycle as a hit write to 0x4002 -> the write is issued first, then the fill begins the following cycle and overwrites address 2.
- Assert rst at fill address 7 -> vram_wren=0, fill_busy=0, no fill_done, and the next CPU read is served normally.
- Write and read to 0x4001 in the same cycle with data 1234 -> write issued, no rvalid, no stall.
